// File: rtl/cacheline_burst_pkg.sv
// Shared types and helpers for the LLC <-> burst memory adapter.
package cacheline_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_LINE_W  = 256;
  localparam int DEF_BURST_W = 64;
  localparam int DEF_ADDR_W  = 32;
  localparam int MAX_ADDR_W  = 64;

  // Clear the low 'off' byte-offset bits so the address points at a line start.
  function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned off);
    logic [MAX_ADDR_W-1:0] mask;
    mask = ~((64'd1 << off) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// One cacheline of storage, loadable as a whole line or one beat at a time,
// with a beat-wide read port and the full line always visible.
module line_beat_buffer
  import cacheline_burst_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int BURST_W = DEF_BURST_W,
  localparam int BEATS  = LINE_W / BURST_W,
  localparam int IDX_W  = $clog2(BEATS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               wr_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [BURST_W-1:0] wr_beat_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [BURST_W-1:0] rd_beat_o,
  output logic [LINE_W-1:0]  line_o
);

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;

  // Next line contents: a full-line load takes priority over a single-beat write.
  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (wr_i) begin
      line_d[wr_idx_i*BURST_W +: BURST_W] = wr_beat_i;
    end
  end

  // Line storage register, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_beat_o = line_q[rd_idx_i*BURST_W +: BURST_W];
  assign line_o    = line_q;

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Bridge between the LLC and burst memory: splits a cacheline into ascending
// memory beats for writeback, assembles beats into a line for fill, and can
// chain a writeback and a fill off a single LLC handshake.
module cacheline_burst_adapter
  import cacheline_burst_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               llc_read_i,
  input  logic               llc_write_i,
  input  logic [ADDR_W-1:0]  llc_address_i,
  input  logic [ADDR_W-1:0]  llc_wb_address_i,
  input  logic [LINE_W-1:0]  llc_line_i,
  output logic [LINE_W-1:0]  llc_line_o,
  output logic               llc_ready_o,
  output logic               llc_resp_o,
  input  logic [BURST_W-1:0] mem_burst_i,
  output logic [BURST_W-1:0] mem_burst_o,
  output logic [ADDR_W-1:0]  mem_address_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  input  logic               mem_resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  // Reject geometries the beat indexing cannot represent.
  if (LINE_W % BURST_W != 0) begin : g_chk_div
    $error("LINE_W must be a multiple of BURST_W");
  end
  if (BEATS < 2) begin : g_chk_beats
    $error("LINE_W/BURST_W must be at least 2");
  end
  if ((BEATS & (BEATS - 1)) != 0) begin : g_chk_pow2
    $error("LINE_W/BURST_W must be a power of two");
  end
  if (ADDR_W > MAX_ADDR_W || ADDR_W <= OFF) begin : g_chk_addr
    $error("ADDR_W out of supported range");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              comb_q, comb_d;

  logic               buf_load;
  logic               buf_wr;
  logic [BURST_W-1:0] buf_beat;
  logic [ADDR_W-1:0]  fill_aligned;
  logic [ADDR_W-1:0]  wb_aligned;

  assign fill_aligned = ADDR_W'(line_align(MAX_ADDR_W'(llc_address_i), OFF));
  assign wb_aligned   = ADDR_W'(line_align(MAX_ADDR_W'(llc_wb_address_i), OFF));

  line_beat_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (buf_load),
    .line_i    (llc_line_i),
    .wr_i      (buf_wr),
    .wr_idx_i  (cnt_q),
    .wr_beat_i (mem_burst_i),
    .rd_idx_i  (cnt_q),
    .rd_beat_o (buf_beat),
    .line_o    (llc_line_o)
  );

  // Next-state, request latching and beat sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_addr_d = fill_addr_q;
    wb_addr_d   = wb_addr_q;
    maddr_d     = maddr_q;
    comb_d      = comb_q;
    buf_load    = 1'b0;
    buf_wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (llc_read_i || llc_write_i) begin
          fill_addr_d = fill_aligned;
          wb_addr_d   = wb_aligned;
          comb_d      = llc_read_i & llc_write_i;
          cnt_d       = '0;
          buf_load    = llc_write_i;
          if (llc_write_i) begin
            state_d = WB;
            maddr_d = wb_aligned;
          end else begin
            state_d = FILL;
            maddr_d = fill_aligned;
          end
        end
      end
      WB: begin
        if (mem_resp_i) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (comb_q) begin
              // Fill follows immediately; switch the address on the same edge.
              state_d = FILL;
              maddr_d = fill_addr_q;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FILL: begin
        if (mem_resp_i) begin
          buf_wr = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and address registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      maddr_q     <= '0;
      comb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_addr_q <= fill_addr_d;
      wb_addr_q   <= wb_addr_d;
      maddr_q     <= maddr_d;
      comb_q      <= comb_d;
    end
  end

  assign llc_ready_o   = (state_q == IDLE);
  assign llc_resp_o    = (state_q == DONE);
  assign mem_write_o   = (state_q == WB);
  assign mem_read_o    = (state_q == FILL);
  assign mem_address_o = maddr_q;
  assign mem_burst_o   = (state_q == WB) ? buf_beat : '0;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Bench for cacheline_burst_adapter: default 256/64 instance plus a 512/64 instance.
module tb_cacheline_burst_adapter;

  localparam int LW  = 256;
  localparam int BW  = 64;
  localparam int AW  = 32;
  localparam int WLW = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          llc_read_i, llc_write_i;
  logic [AW-1:0] llc_address_i, llc_wb_address_i;
  logic [LW-1:0] llc_line_i, llc_line_o;
  logic          llc_ready_o, llc_resp_o;
  logic [BW-1:0] mem_burst_i, mem_burst_o;
  logic [AW-1:0] mem_address_o;
  logic          mem_read_o, mem_write_o, mem_resp_i;

  logic           w_read, w_write;
  logic [AW-1:0]  w_addr, w_wbaddr;
  logic [WLW-1:0] w_line_i, w_line_o;
  logic           w_ready, w_resp;
  logic [BW-1:0]  w_burst_i, w_burst_o;
  logic [AW-1:0]  w_maddr;
  logic           w_mrd, w_mwr, w_mresp;

  cacheline_burst_adapter #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset),
    .llc_read_i(llc_read_i), .llc_write_i(llc_write_i),
    .llc_address_i(llc_address_i), .llc_wb_address_i(llc_wb_address_i),
    .llc_line_i(llc_line_i), .llc_line_o(llc_line_o),
    .llc_ready_o(llc_ready_o), .llc_resp_o(llc_resp_o),
    .mem_burst_i(mem_burst_i), .mem_burst_o(mem_burst_o),
    .mem_address_o(mem_address_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_resp_i(mem_resp_i)
  );

  cacheline_burst_adapter #(.LINE_W(WLW), .BURST_W(BW), .ADDR_W(AW)) u_wide (
    .clk(clk), .reset(reset),
    .llc_read_i(w_read), .llc_write_i(w_write),
    .llc_address_i(w_addr), .llc_wb_address_i(w_wbaddr),
    .llc_line_i(w_line_i), .llc_line_o(w_line_o),
    .llc_ready_o(w_ready), .llc_resp_o(w_resp),
    .mem_burst_i(w_burst_i), .mem_burst_o(w_burst_o),
    .mem_address_o(w_maddr), .mem_read_o(w_mrd),
    .mem_write_o(w_mwr), .mem_resp_i(w_mresp)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_t;

  wr_t            exp_wr[$];
  logic [AW-1:0]  exp_rd[$];
  logic [LW-1:0]  exp_line[$];
  logic [BW-1:0]  rd_data[$];
  wr_t            w_exp_wr[$];
  logic [AW-1:0]  w_exp_rd[$];
  logic [WLW-1:0] w_exp_line[$];

  int n_tests = 0;
  int n_fail = 0;
  int resp_cnt = 0;
  int w_resp_cnt = 0;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  // Monitor for the 256-bit instance: compares every presented beat/response to the scoreboard.
  always @(negedge clk) begin
    if (mem_write_o === 1'b1) begin
      if (exp_wr.size() == 0) flag("wr_unexpected");
      else begin
        check("wr_addr", 512'(mem_address_o), 512'(exp_wr[0].addr));
        check("wr_data", 512'(mem_burst_o), 512'(exp_wr[0].data));
        if (mem_resp_i) void'(exp_wr.pop_front());
      end
    end
    if (mem_read_o === 1'b1) begin
      if (exp_rd.size() == 0) flag("rd_unexpected");
      else begin
        check("rd_addr", 512'(mem_address_o), 512'(exp_rd[0]));
        check("rd_burst_zero", 512'(mem_burst_o), 512'(0));
        if (mem_resp_i) void'(exp_rd.pop_front());
      end
    end
    if (llc_resp_o === 1'b1) begin
      resp_cnt++;
      if (exp_line.size() == 0) flag("resp_unexpected");
      else check("llc_line", 512'(llc_line_o), 512'(exp_line.pop_front()));
    end
  end

  // Monitor for the 512-bit instance.
  always @(negedge clk) begin
    if (w_mwr === 1'b1) begin
      if (w_exp_wr.size() == 0) flag("w_wr_unexpected");
      else begin
        check("w_wr_addr", 512'(w_maddr), 512'(w_exp_wr[0].addr));
        check("w_wr_data", 512'(w_burst_o), 512'(w_exp_wr[0].data));
        if (w_mresp) void'(w_exp_wr.pop_front());
      end
    end
    if (w_mrd === 1'b1) begin
      if (w_exp_rd.size() == 0) flag("w_rd_unexpected");
      else begin
        check("w_rd_addr", 512'(w_maddr), 512'(w_exp_rd[0]));
        if (w_mresp) void'(w_exp_rd.pop_front());
      end
    end
    if (w_resp === 1'b1) begin
      w_resp_cnt++;
      if (w_exp_line.size() == 0) flag("w_resp_unexpected");
      else check("w_line", w_line_o, w_exp_line.pop_front());
    end
  end

  task automatic push_wr(input logic [AW-1:0] a, input logic [LW-1:0] line);
    wr_t e;
    for (int k = 0; k < LW / BW; k++) begin
      e.addr = a;
      e.data = line[k*BW +: BW];
      exp_wr.push_back(e);
    end
  endtask

  // Issue one LLC request, serve memory with 'stall' idle cycles before each ack,
  // and check the acceptance-to-response cycle count and the single response.
  task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [AW-1:0] wbaddr, input logic [LW-1:0] line,
                        input int stall, input int exp_cycles, input string nm);
    int cyc, st, r0;
    bit done;
    @(posedge clk); #1;
    check({nm, "_ready"}, 512'(llc_ready_o), 512'(1));
    r0 = resp_cnt;
    llc_read_i = rd; llc_write_i = wr;
    llc_address_i = addr; llc_wb_address_i = wbaddr; llc_line_i = line;
    @(posedge clk); #1;
    llc_read_i = 1'b0; llc_write_i = 1'b0;
    llc_address_i = '1; llc_wb_address_i = '1; llc_line_i = '1;
    cyc = 0; st = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      cyc++;
      mem_resp_i = 1'b0;
      mem_burst_i = '0;
      if (llc_resp_o) done = 1'b1;
      else if (mem_read_o || mem_write_o) begin
        if (st == stall) begin
          mem_resp_i = 1'b1;
          st = 0;
          if (mem_read_o && rd_data.size() > 0) mem_burst_i = rd_data.pop_front();
        end else st++;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) $display("FAIL %s_timeout: got no llc_resp_o, expected one", nm);
    check({nm, "_cycles"}, 512'(cyc), 512'(exp_cycles));
    @(posedge clk); #1;
    check({nm, "_ready_after"}, 512'(llc_ready_o), 512'(1));
    check({nm, "_resp_count"}, 512'(resp_cnt - r0), 512'(1));
  endtask

  localparam logic [BW-1:0] B1 = {16{4'h1}}, B2 = {16{4'h2}}, B3 = {16{4'h3}}, B4 = {16{4'h4}};
  localparam logic [BW-1:0] B5 = {16{4'h5}}, B6 = {16{4'h6}}, B7 = {16{4'h7}}, B8 = {16{4'h8}};
  localparam logic [LW-1:0] LINE_WB = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                                       64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
  localparam logic [LW-1:0] LINE_CB = {64'hC3C3_0000_C3C3_0003, 64'hC2C2_0000_C2C2_0002,
                                       64'hC1C1_0000_C1C1_0001, 64'hC0C0_0000_C0C0_0000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, cyc;
    bit done;
    int fi;
    logic [WLW-1:0] wline, fline;
    wr_t e;

    reset = 1'b1;
    llc_read_i = 1'b0; llc_write_i = 1'b0; llc_address_i = '0; llc_wb_address_i = '0;
    llc_line_i = '0; mem_burst_i = '0; mem_resp_i = 1'b0;
    w_read = 1'b0; w_write = 1'b0; w_addr = '0; w_wbaddr = '0; w_line_i = '0;
    w_burst_i = '0; w_mresp = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    check("rst_ready", 512'(llc_ready_o), 512'(1));
    check("rst_resp", 512'(llc_resp_o), 512'(0));
    check("rst_mem_read", 512'(mem_read_o), 512'(0));
    check("rst_mem_write", 512'(mem_write_o), 512'(0));
    check("rst_burst", 512'(mem_burst_o), 512'(0));
    check("rst_addr", 512'(mem_address_o), 512'(0));
    check("rst_line", 512'(llc_line_o), 512'(0));
    check("rst_w_ready", 512'(w_ready), 512'(1));
    check("rst_w_line", w_line_o, 512'(0));

    // Plain fill, no stalls.
    repeat (4) exp_rd.push_back(32'h1234_5660);
    rd_data.push_back(B1); rd_data.push_back(B2); rd_data.push_back(B3); rd_data.push_back(B4);
    exp_line.push_back({B4, B3, B2, B1});
    do_req(1'b1, 1'b0, 32'h1234_5678, 32'h0, '0, 0, 5, "fill");

    // Plain writeback; afterwards the line output shows the written line.
    push_wr(32'h0000_0040, LINE_WB);
    exp_line.push_back(LINE_WB);
    do_req(1'b0, 1'b1, 32'h0, 32'h0000_0040, LINE_WB, 0, 5, "wb");

    // Combined writeback then fill: 9 cycles means no gap between the two bursts.
    push_wr(32'h0000_0100, LINE_CB);
    repeat (4) exp_rd.push_back(32'h0000_0200);
    rd_data.push_back(B5); rd_data.push_back(B6); rd_data.push_back(B7); rd_data.push_back(B8);
    exp_line.push_back({B8, B7, B6, B5});
    do_req(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0100, LINE_CB, 0, 9, "comb");

    // Stalled fill and stalled writeback give the same results.
    repeat (4) exp_rd.push_back(32'h1234_5660);
    rd_data.push_back(B1); rd_data.push_back(B2); rd_data.push_back(B3); rd_data.push_back(B4);
    exp_line.push_back({B4, B3, B2, B1});
    do_req(1'b1, 1'b0, 32'h1234_5678, 32'h0, '0, 3, 17, "fill_stall");
    push_wr(32'h0000_0040, LINE_WB);
    exp_line.push_back(LINE_WB);
    do_req(1'b0, 1'b1, 32'h0, 32'h0000_0040, LINE_WB, 3, 17, "wb_stall");

    // Reset during fill beat 2, with a request held through reset.
    r0 = resp_cnt;
    repeat (4) exp_rd.push_back(32'h0000_1000);
    @(posedge clk); #1;
    llc_read_i = 1'b1; llc_address_i = 32'h0000_1010;
    @(posedge clk); #1;
    llc_read_i = 1'b0; mem_resp_i = 1'b1; mem_burst_i = B1;
    @(posedge clk); #1;
    mem_burst_i = B2;
    @(posedge clk); #1;
    mem_resp_i = 1'b0; mem_burst_i = '0; reset = 1'b1; llc_read_i = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; llc_read_i = 1'b0;
    exp_rd.delete();
    check("abort_mem_read", 512'(mem_read_o), 512'(0));
    check("abort_ready", 512'(llc_ready_o), 512'(1));
    check("abort_line", 512'(llc_line_o), 512'(0));
    @(posedge clk); #1;
    check("abort_still_idle", 512'(mem_read_o), 512'(0));
    check("abort_no_resp", 512'(resp_cnt - r0), 512'(0));

    // Fill after the abort completes normally.
    repeat (4) exp_rd.push_back(32'h0000_2020);
    rd_data.push_back(B8); rd_data.push_back(B6); rd_data.push_back(B4); rd_data.push_back(B2);
    exp_line.push_back({B2, B4, B6, B8});
    do_req(1'b1, 1'b0, 32'h0000_2024, 32'h0, '0, 0, 5, "fill_after_rst");

    // 512-bit line: combined 8-beat writeback at 0x12C0 then fill from 0xABE4 -> 0xABC0.
    for (int k = 0; k < 8; k++) begin
      wline[k*BW +: BW] = 64'(k) * 64'h0101_0101_0101_0101;
      fline[k*BW +: BW] = 64'(k + 8) * 64'h0101_0101_0101_0101;
      e.addr = 32'h0000_12C0;
      e.data = wline[k*BW +: BW];
      w_exp_wr.push_back(e);
      w_exp_rd.push_back(32'h0000_ABC0);
    end
    w_exp_line.push_back(fline);
    r0 = w_resp_cnt;
    @(posedge clk); #1;
    w_read = 1'b1; w_write = 1'b1; w_addr = 32'h0000_ABE4; w_wbaddr = 32'h0000_12C0; w_line_i = wline;
    @(posedge clk); #1;
    w_read = 1'b0; w_write = 1'b0; w_addr = '1; w_wbaddr = '1; w_line_i = '1;
    cyc = 0; fi = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      cyc++;
      w_mresp = 1'b0;
      w_burst_i = '0;
      if (w_resp) done = 1'b1;
      else if (w_mrd || w_mwr) begin
        w_mresp = 1'b1;
        if (w_mrd && fi < 8) begin
          w_burst_i = fline[fi*BW +: BW];
          fi++;
        end
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    if (!done) $display("FAIL wide_timeout: got no llc_resp_o, expected one");
    check("wide_cycles", 512'(cyc), 512'(17));
    @(posedge clk); #1;
    check("wide_ready_after", 512'(w_ready), 512'(1));
    check("wide_resp_count", 512'(w_resp_cnt - r0), 512'(1));

    // Everything promised was observed.
    repeat (2) @(posedge clk);
    #1;
    check("left_wr", 512'(exp_wr.size()), 512'(0));
    check("left_rd", 512'(exp_rd.size()), 512'(0));
    check("left_line", 512'(exp_line.size()), 512'(0));
    check("left_w_wr", 512'(w_exp_wr.size()), 512'(0));
    check("left_w_rd", 512'(w_exp_rd.size()), 512'(0));
    check("left_w_line", 512'(w_exp_line.size()), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
Parametrised bridge between the lowest-level cache (LLC) and burst memory. It converts one LINE_W-bit cacheline into BEATS = LINE_W/BURST_W memory beats, and the reverse. It adds three things over the fixed 256/64 adapter:
- a combined writeback-then-fill request that serves a dirty eviction and a refill in one handshake;
- a ready indication;
- full request latching, so the LLC may drop its inputs after acceptance.

Parameters:
LINE_W, 256, cacheline width in bits; power of two, multiple of BURST_W.
BURST_W, 64, memory beat width in bits; BEATS = LINE_W/BURST_W must be >= 2.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
llc_read_i  in  1  fill request
llc_write_i  in  1  writeback request
llc_address_i  in  ADDR_W  fill line address
llc_wb_address_i  in  ADDR_W  writeback (victim) line address
llc_line_i  in  LINE_W  writeback data
llc_line_o  out  LINE_W  fill data
llc_ready_o  out  1  adapter idle, request will be accepted
llc_resp_o  out  1  one-cycle completion pulse
mem_burst_i  in  BURST_W  read beat data
mem_burst_o  out  BURST_W  write beat data
mem_address_o  out  ADDR_W  line-aligned memory address
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
mem_resp_i  in  1  per-beat memory acknowledge

Behaviour:
- Reset and clocking: one clock. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE; beat counter = 0; line buffer = 0.
  - llc_ready_o = 1, llc_resp_o = 0, mem_read_o = 0, mem_write_o = 0.
  - mem_burst_o = 0, mem_address_o = 0, llc_line_o = 0.
- Constants: OFF = $clog2(LINE_W/8) byte-offset bits. CNT_W = $clog2(BEATS).
- State machine:
  - States: IDLE, WB, FILL, DONE.
  - llc_ready_o = (state == IDLE).
  - mem_write_o = (state == WB); mem_read_o = (state == FILL).
  - llc_resp_o = (state == DONE).
- Acceptance (IDLE only; a request is accepted at the clock edge where it is sampled):
  - Latch fill_addr = {llc_address_i[ADDR_W-1:OFF], OFF zeros}.
  - Latch wb_addr = {llc_wb_address_i[ADDR_W-1:OFF], OFF zeros}.
  - Latch combined flag = llc_read_i & llc_write_i.
  - If llc_write_i is set, load the buffer from llc_line_i.
  - Clear the beat counter.
  - Next state: WB if llc_write_i is set, else FILL if llc_read_i is set, else remain in IDLE.
- Input qualification: LLC request inputs are ignored outside IDLE. mem_resp_i is ignored outside WB and FILL.
- mem_address_o:
  - wb_addr in WB; fill_addr in FILL.
  - Holds its last value otherwise.
  - Constant for the whole burst.
- Beat order: ascending. Beat k occupies line bits [k*BURST_W +: BURST_W].
- WB state:
  - mem_burst_o = buffer beat[count]; mem_burst_o = 0 in all other states.
  - On mem_resp_i, count increments.
  - On mem_resp_i with count == BEATS-1: count clears, and next state is FILL if combined, else DONE.
- WB to FILL handoff: no idle cycle. mem_write_o falls and mem_read_o rises on the same edge.
- FILL state:
  - On mem_resp_i, buffer beat[count] <= mem_burst_i and count increments.
  - On the last beat, next state is DONE.
- Stalls: mem_resp_i may stay low for any number of cycles. The state, count and outputs hold meanwhile.
- DONE: llc_resp_o is high for exactly one cycle, then the next state is IDLE. A single llc_resp_o is issued per accepted request, including combined requests.
- llc_line_o:
  - Driven continuously from the buffer.
  - Valid from the DONE cycle of a fill until the next accepted request.
  - After a pure writeback it equals the written line.
- Wrap-around: the counter wraps only via the explicit clear at the last beat. It never aliases mid-burst.
- Reset mid-transaction: the next edge returns to IDLE and clears the counter. mem_read_o/mem_write_o deassert in the following cycle. No llc_resp_o is issued for the aborted request.
- Reset with a pending request: a request present while reset is high is not accepted.
- Elaboration assertions: LINE_W % BURST_W == 0, BEATS >= 2, BEATS a power of two.

Decomposition:
- Package cacheline_burst_pkg holds:
  - the state enum typedef (IDLE, WB, FILL, DONE);
  - default-width localparams;
  - a helper function for line alignment.
- Sub-module line_beat_buffer(LINE_W, BURST_W) holds:
  - parallel load of the full line;
  - per-beat write at an index;
  - per-beat read mux;
  - the full-line output.

Test Plan:
- Fill, default parameters: llc_read_i with address 0x1234_5678; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with mem_resp_i on four consecutive cycles. Required: mem_address_o = 0x1234_5660, mem_read_o high for 4 cycles, llc_line_o = {0x44..,0x33..,0x22..,0x11..}, one llc_resp_o pulse, llc_ready_o high the next cycle.
- Writeback: llc_write_i with line {D3,D2,D1,D0} and wb address 0x0000_0040, with inputs dropped after acceptance. Required: mem_burst_o = D0, D1, D2, D3 in order, mem_write_o high 4 cycles, single llc_resp_o.
- Combined request: read and write together, wb 0x100, fill 0x200. Required: 4 write beats at 0x100, then immediately 4 read beats at 0x200 with no gap, then exactly one llc_resp_o.
- Stalls: insert 3 idle cycles before each mem_resp_i. Required: output state holds, and the result is identical to the no-stall case.
- Reset: assert reset during FILL beat 2. Required: IDLE next cycle, mem_read_o = 0, no llc_resp_o. A subsequent fill completes correctly.
- Parameterisation: LINE_W=512, BURST_W=64. Required: 8-beat fill and writeback, address aligned to 64 bytes (0x..C0 → 0x..C0, 0x..E4 → 0x..C0).
